// File: rtl/stream_distributor_pkg.sv
// Shared types and constants for the stream_distributor slice.
// Imported by stream_distributor_fifo and stream_distributor.
package hierInclude_package;

    typedef enum logic {
        DIST_RR    = 1'b0,
        DIST_BCAST = 1'b1
    } dist_mode_e;

    localparam int DIST_MAX_OUT = 8;
    localparam int DIST_CNT_W   = 16;

    // Default beat payload carried between the producer and consumer blocks.
    typedef logic [7:0] aSt;

    // Saturating increment used by the delivered-beat counters.
    function automatic logic [DIST_CNT_W-1:0] sat_inc(input logic [DIST_CNT_W-1:0] v);
        return (v == {DIST_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/stream_distributor_fifo.sv
// Single-clock FIFO used as the per-output buffer of stream_distributor.
// Head is forced to zero while empty so stale storage never shows on out_data.
module stream_distributor_fifo
    import hierInclude_package::*;
#(
    parameter type data_t = aSt,
    parameter int  DEPTH  = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  data_t wdata,
    input  logic  pop,
    output logic  full,
    output logic  empty,
    output data_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    data_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; validity comes from count, and
    // the head mux below hides whatever the array holds after reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/stream_distributor.sv
// One-to-NUM_OUT rdy/vld distributor, round-robin or broadcast per MODE.
// Optional per-output pop counters are built when STREAM_DISTRIBUTOR_STATS_EN is defined.
module stream_distributor
    import hierInclude_package::*;
#(
    parameter type        data_t  = aSt,
    parameter int         NUM_OUT = 2,
    parameter int         DEPTH   = 2,
    parameter dist_mode_e MODE    = DIST_RR
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_vld,
    output logic                                    in_rdy,
    input  logic [$bits(data_t)-1:0]                in_data,
    output logic [NUM_OUT-1:0]                      out_vld,
    input  logic [NUM_OUT-1:0]                      out_rdy,
    output logic [NUM_OUT-1:0][$bits(data_t)-1:0]   out_data,
    output logic [NUM_OUT-1:0][DIST_CNT_W-1:0]      out_beats
);

    localparam int PTR_W = $clog2(NUM_OUT);

    logic [NUM_OUT-1:0] push;
    logic [NUM_OUT-1:0] pop;
    logic [NUM_OUT-1:0] full;
    logic [NUM_OUT-1:0] empty;
    logic [PTR_W-1:0]   rr_ptr;
    logic               space_ok;
    logic               live_q;
    logic               accept;

    // Holds in_rdy low during reset and releases it on the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live_q <= 1'b0;
        else        live_q <= 1'b1;
    end

    assign in_rdy  = live_q && space_ok;
    assign accept  = in_vld && in_rdy;
    assign out_vld = ~empty;
    assign pop     = out_vld & out_rdy;

    generate
        if (MODE == DIST_RR) begin : g_rr
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rr_ptr <= '0;
                end else if (accept) begin
                    rr_ptr <= (rr_ptr == PTR_W'(NUM_OUT - 1)) ? '0 : rr_ptr + 1'b1;
                end
            end

            // NOTE: every always_comb output gets a default first so no latch
            // can be inferred for the unselected channels.
            always_comb begin
                space_ok = 1'b0;
                push     = '0;
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (rr_ptr == PTR_W'(i)) begin
                        space_ok = !full[i];
                        push[i]  = accept;
                    end
                end
            end
        end else begin : g_bcast
            assign rr_ptr   = '0;
            assign space_ok = ~|full;
            assign push     = {NUM_OUT{accept}};
        end
    endgenerate

    generate
        for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
            stream_distributor_fifo #(
                .data_t (data_t),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst_n (rst_n),
                .push  (push[i]),
                .wdata (in_data),
                .pop   (pop[i]),
                .full  (full[i]),
                .empty (empty[i]),
                .head  (out_data[i])
            );
        end
    endgenerate

`ifdef STREAM_DISTRIBUTOR_STATS_EN
    generate
        for (genvar i = 0; i < NUM_OUT; i++) begin : g_stats
            logic [DIST_CNT_W-1:0] beats_q;

            // NOTE: sequential state uses non-blocking assignments only.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      beats_q <= '0;
                else if (pop[i]) beats_q <= sat_inc(beats_q);
            end

            assign out_beats[i] = beats_q;
        end
    endgenerate
`else
    assign out_beats = '0;
`endif

endmodule

// File: tb/tb_stream_distributor.sv
// Directed bench for stream_distributor: a 3-way round-robin and a 4-way broadcast instance.
// Honours STREAM_DISTRIBUTOR_STATS_EN for the counter expectations.
module tb_stream_distributor;
    import hierInclude_package::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Round-robin instance, 3 outputs.
    logic             rr_in_vld = 1'b0;
    logic             rr_in_rdy;
    logic [7:0]       rr_in_data = '0;
    logic [2:0]       rr_out_vld;
    logic [2:0]       rr_out_rdy = '0;
    logic [2:0][7:0]  rr_out_data;
    logic [2:0][15:0] rr_out_beats;

    // Broadcast instance, 4 outputs.
    logic             bc_in_vld = 1'b0;
    logic             bc_in_rdy;
    logic [7:0]       bc_in_data = '0;
    logic [3:0]       bc_out_vld;
    logic [3:0]       bc_out_rdy = '0;
    logic [3:0][7:0]  bc_out_data;
    logic [3:0][15:0] bc_out_beats;

    stream_distributor #(.data_t(aSt), .NUM_OUT(3), .DEPTH(2), .MODE(DIST_RR)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_vld(rr_in_vld), .in_rdy(rr_in_rdy), .in_data(rr_in_data),
        .out_vld(rr_out_vld), .out_rdy(rr_out_rdy), .out_data(rr_out_data), .out_beats(rr_out_beats)
    );

    stream_distributor #(.data_t(aSt), .NUM_OUT(4), .DEPTH(2), .MODE(DIST_BCAST)) u_bc (
        .clk(clk), .rst_n(rst_n), .in_vld(bc_in_vld), .in_rdy(bc_in_rdy), .in_data(bc_in_data),
        .out_vld(bc_out_vld), .out_rdy(bc_out_rdy), .out_data(bc_out_data), .out_beats(bc_out_beats)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic            vld;
        logic [7:0]      data;
        logic [2:0]      rdy;
        logic            exp_rdy;
        logic [2:0]      exp_vld;
        logic [2:0][7:0] exp_d;
    } vec_t;

    function automatic vec_t mk(input logic vld, input logic [7:0] d, input logic [2:0] rdy,
                                input logic er, input logic [2:0] ev,
                                input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        vec_t r;
        r.vld = vld; r.data = d; r.rdy = rdy; r.exp_rdy = er; r.exp_vld = ev;
        r.exp_d[0] = e0; r.exp_d[1] = e1; r.exp_d[2] = e2;
        return r;
    endfunction

    // Pop monitor for the broadcast instance.
    logic       mon_en = 1'b0;
    logic [7:0] got [4][16];
    int         got_n [4] = '{default: 0};

    always @(posedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 4; i++) begin
                if (bc_out_vld[i] && bc_out_rdy[i]) begin
                    if (got_n[i] < 16) got[i][got_n[i]] <= bc_out_data[i];
                    got_n[i] <= got_n[i] + 1;
                end
            end
        end
    end

    vec_t vecs[$];
    int   acc;

    initial begin
        // Round-robin: full-rate, then out1 stalled with a full-plus-pop cycle.
        vecs.push_back(mk(1, 8'h10, 3'b111, 1, 3'b000, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(1, 8'h11, 3'b111, 1, 3'b001, 8'h10, 8'h00, 8'h00));
        vecs.push_back(mk(1, 8'h12, 3'b111, 1, 3'b010, 8'h00, 8'h11, 8'h00));
        vecs.push_back(mk(1, 8'h13, 3'b111, 1, 3'b100, 8'h00, 8'h00, 8'h12));
        vecs.push_back(mk(1, 8'h14, 3'b111, 1, 3'b001, 8'h13, 8'h00, 8'h00));
        vecs.push_back(mk(1, 8'h15, 3'b111, 1, 3'b010, 8'h00, 8'h14, 8'h00));
        vecs.push_back(mk(0, 8'h00, 3'b111, 1, 3'b100, 8'h00, 8'h00, 8'h15));
        vecs.push_back(mk(0, 8'h00, 3'b111, 1, 3'b000, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(1, 8'h20, 3'b101, 1, 3'b000, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(1, 8'h21, 3'b101, 1, 3'b001, 8'h20, 8'h00, 8'h00));
        vecs.push_back(mk(1, 8'h22, 3'b101, 1, 3'b010, 8'h00, 8'h21, 8'h00));
        vecs.push_back(mk(1, 8'h23, 3'b101, 1, 3'b110, 8'h00, 8'h21, 8'h22));
        vecs.push_back(mk(1, 8'h24, 3'b101, 1, 3'b011, 8'h23, 8'h21, 8'h00));
        vecs.push_back(mk(1, 8'h25, 3'b101, 1, 3'b010, 8'h00, 8'h21, 8'h00));
        vecs.push_back(mk(1, 8'h26, 3'b101, 1, 3'b110, 8'h00, 8'h21, 8'h25));
        vecs.push_back(mk(1, 8'h27, 3'b101, 0, 3'b011, 8'h26, 8'h21, 8'h00));
        vecs.push_back(mk(1, 8'h27, 3'b111, 0, 3'b010, 8'h00, 8'h21, 8'h00));
        vecs.push_back(mk(1, 8'h27, 3'b111, 1, 3'b010, 8'h00, 8'h24, 8'h00));
        vecs.push_back(mk(0, 8'h00, 3'b111, 1, 3'b010, 8'h00, 8'h27, 8'h00));
        vecs.push_back(mk(0, 8'h00, 3'b111, 1, 3'b000, 8'h00, 8'h00, 8'h00));

        // Reset state.
        #12;
        check("reset_rr_in_rdy", 32'(rr_in_rdy), 32'd0);
        check("reset_bc_in_rdy", 32'(bc_in_rdy), 32'd0);
        check("reset_rr_out_vld", 32'(rr_out_vld), 32'd0);
        check("reset_bc_out_data", bc_out_data, 32'd0);
        check("reset_bc_beats0", 32'(bc_out_beats[0]), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[n]) begin
            rr_in_vld  = vecs[n].vld;
            rr_in_data = vecs[n].data;
            rr_out_rdy = vecs[n].rdy;
            #1;
            check($sformatf("v%0d_in_rdy", n), 32'(rr_in_rdy), 32'(vecs[n].exp_rdy));
            check($sformatf("v%0d_out_vld", n), 32'(rr_out_vld), 32'(vecs[n].exp_vld));
            for (int k = 0; k < 3; k++)
                if (vecs[n].exp_vld[k])
                    check($sformatf("v%0d_out_data%0d", n, k), 32'(rr_out_data[k]), 32'(vecs[n].exp_d[k]));
            @(posedge clk); #1;
        end
        rr_in_vld = 1'b0;

        // Broadcast with out2 stalled: two beats fit, then backpressure.
        mon_en     = 1'b1;
        bc_out_rdy = 4'b1011;
        bc_in_vld  = 1'b1;
        acc        = 0;
        bc_in_data = 8'h30;
        for (int c = 0; c < 6; c++) begin
            if (bc_in_vld && bc_in_rdy) acc++;
            @(posedge clk); #1;
            bc_in_data = 8'(8'h30 + acc);
        end
        check("bc_stall_accepted", 32'(acc), 32'd2);
        check("bc_stall_in_rdy", 32'(bc_in_rdy), 32'd0);
        bc_out_rdy = 4'b1111;
        for (int c = 0; c < 60 && acc < 8; c++) begin
            if (bc_in_vld && bc_in_rdy) acc++;
            @(posedge clk); #1;
            bc_in_data = 8'(8'h30 + acc);
            if (acc >= 8) bc_in_vld = 1'b0;
        end
        bc_in_vld = 1'b0;
        check("bc_total_accepted", 32'(acc), 32'd8);
        repeat (6) @(posedge clk);
        #1;
        mon_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bc_out%0d_count", i), 32'(got_n[i]), 32'd8);
            for (int k = 0; k < 8; k++)
                check($sformatf("bc_out%0d_beat%0d", i, k), 32'(got[i][k]), 32'(8'h30 + k));
        end

        // Asynchronous reset with three beats buffered in the round-robin instance.
        rr_out_rdy = 3'b000;
        rr_in_vld  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rr_in_data = 8'(8'h40 + k);
            @(posedge clk); #1;
        end
        rr_in_vld = 1'b0;
        check("pre_reset_out_vld", 32'(rr_out_vld), 32'b111);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_vld", 32'(rr_out_vld), 32'd0);
        check("async_reset_in_rdy", 32'(rr_in_rdy), 32'd0);
        check("async_reset_out_data", rr_out_data, 32'd0);
        check("async_reset_beats0", 32'(rr_out_beats[0]), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_in_rdy", 32'(rr_in_rdy), 32'd1);
        rr_out_rdy = 3'b111;
        rr_in_vld  = 1'b1;
        rr_in_data = 8'h50;
        @(posedge clk); #1;
        rr_in_vld = 1'b0;
        check("post_reset_first_vld", 32'(rr_out_vld), 32'b001);
        check("post_reset_first_data", 32'(rr_out_data[0]), 32'h50);
        @(posedge clk); #1;
`ifdef STREAM_DISTRIBUTOR_STATS_EN
        check("rr_beats0_one", 32'(rr_out_beats[0]), 32'd1);
`else
        check("rr_beats0_zero", 32'(rr_out_beats[0]), 32'd0);
`endif

        // Counter saturation: broadcast at full rate well past 65535 pops.
        bc_out_rdy = 4'b1111;
        bc_in_vld  = 1'b1;
        bc_in_data = 8'h77;
        repeat (70000) @(posedge clk);
        #1;
`ifdef STREAM_DISTRIBUTOR_STATS_EN
        check("bc_beats0_sat", 32'(bc_out_beats[0]), 32'hFFFF);
        check("bc_beats3_sat", 32'(bc_out_beats[3]), 32'hFFFF);
`else
        check("bc_beats0_zero", 32'(bc_out_beats[0]), 32'd0);
        check("bc_beats3_zero", 32'(bc_out_beats[3]), 32'd0);
`endif
        check("bc_stream_in_rdy", 32'(bc_in_rdy), 32'd1);
        repeat (10) @(posedge clk);
        #1;
`ifdef STREAM_DISTRIBUTOR_STATS_EN
        check("bc_beats0_hold", 32'(bc_out_beats[0]), 32'hFFFF);
`else
        check("bc_beats0_still_zero", 32'(bc_out_beats[0]), 32'd0);
`endif
        bc_in_vld = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
